delay_line_ctrl: RTL and testbench

Circular-buffer controller for the guitar-effects delay path. Accepts one 32-bit signed audio sample per sample strobe, reads the sample written `DELAY` strobes earlier from the two-port delay memory, and mixes it with the dry input. It writes the new sample, optionally with feedback, back to the memory. It is the initiator driving the delay memory's `ADDR1`/`ADDR2`/`WE`/`DI` ports and consuming its `DO1` read data.

---
 rtl/delay_line_ctrl_pkg.sv | 21 ++
 rtl/delay_line_ctrl_if.sv | 30 +++
 rtl/delay_line_ctrl_sat_mac.sv | 25 ++
 rtl/delay_line_ctrl.sv | 133 +++++++++++++
 tb/tb_delay_line_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/delay_line_ctrl_pkg.sv
// delay_pkg: shared state encoding, default geometry and Q0.8 / saturation
// constants for the delay-line controller.
package delay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_MIX
  } state_t;

  localparam int DEF_B      = 15;
  localparam int DEF_T      = 20000;
  localparam int DEF_RD_LAT = 2;

  localparam int Q_SHIFT = 8;

  localparam logic signed [31:0] SAT_MAX = 32'sh7fff_ffff;
  localparam logic signed [31:0] SAT_MIN = 32'sh8000_0000;

endpackage

// File: rtl/delay_line_ctrl_if.sv
// delay_line_if: sample stream handshake plus delay-memory port bundle.
// master = the controller, slave = the surrounding audio path and memory.
interface delay_line_if #(
  parameter int B = delay_pkg::DEF_B
);
  logic        in_valid;
  logic        in_ready;
  logic [31:0] din;
  logic [B-1:0] delay;
  logic [7:0]  gain;
  logic [7:0]  fb;
  logic [B-1:0] addr1;
  logic [31:0] do1;
  logic [B-1:0] addr2;
  logic        we;
  logic [31:0] di;
  logic [31:0] dout;
  logic        dout_valid;
  logic        overrun;

  modport master (
    input  in_valid, din, delay, gain, fb, do1,
    output in_ready, addr1, addr2, we, di, dout, dout_valid, overrun
  );

  modport slave (
    output in_valid, din, delay, gain, fb, do1,
    input  in_ready, addr1, addr2, we, di, dout, dout_valid, overrun
  );
endinterface

// File: rtl/delay_line_ctrl_sat_mac.sv
// delay_sat_mac: y = sat32(acc + ((x * g) >>> 8)), x signed, g unsigned Q0.8.
module delay_sat_mac
  import delay_pkg::*;
(
  input  logic signed [31:0] acc,
  input  logic signed [31:0] x,
  input  logic        [7:0]  g,
  output logic signed [31:0] y
);
  logic signed [39:0] x_ext;
  logic signed [39:0] g_ext;
  logic signed [39:0] prod;
  logic signed [39:0] scaled;
  logic        [40:0] sum;

  assign x_ext  = {{8{x[31]}}, x};
  assign g_ext  = {32'd0, g};
  assign prod   = x_ext * g_ext;
  assign scaled = prod >>> Q_SHIFT;
  assign sum    = {{9{acc[31]}}, acc} + {scaled[39], scaled};

  // Result fits in 32 bits only when bits 40..31 are all copies of the sign.
  assign y = (sum[40:31] == {10{sum[31]}}) ? sum[31:0]
           : (sum[40] ? SAT_MIN : SAT_MAX);
endmodule

// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: circular-buffer delay controller with wet/dry mix.
// Feedback into the buffer is built only when DELAY_LINE_FEEDBACK_EN is defined.
module delay_line_ctrl
  import delay_pkg::*;
#(
  parameter int B      = DEF_B,
  parameter int T      = DEF_T,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic         clk,
  input  logic         rst_n,
  delay_line_if.master bus
);
  localparam int           CW     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [B:0]   T_EXT  = (B + 1)'(T);
  localparam logic [B-1:0] T_MOD  = T_EXT[B-1:0];
  localparam logic [B-1:0] T_LAST = B'(T - 1);

  state_t             state_reg;
  logic [B-1:0]       wr_ptr_reg, d_reg, addr1_reg, addr2_reg;
  logic [B:0]         fill_reg;
  logic [CW-1:0]      wait_cnt_reg;
  logic signed [31:0] din_reg, mix_reg, di_reg, dout_reg;
  logic [7:0]         gain_reg;
  logic               in_ready_reg, we_reg, dout_valid_reg, overrun_reg;

  logic [B-1:0]       d_clamp, rd_addr;
  logic signed [31:0] wet_now, mix_val, wr_val;

  assign d_clamp = ({1'b0, bus.delay} >= T_EXT) ? T_LAST : bus.delay;
  // Adding T modulo 2^B folds a negative tap offset back into 0..T-1.
  assign rd_addr = wr_ptr_reg - d_clamp + ((wr_ptr_reg >= d_clamp) ? '0 : T_MOD);
  // Taps older than the writes since reset hold stale memory; treat them as silence.
  assign wet_now = (d_reg == '0 || fill_reg < {1'b0, d_reg}) ? '0 : $signed(bus.do1);

  delay_sat_mac u_mix (
    .acc (din_reg),
    .x   (wet_now),
    .g   (gain_reg),
    .y   (mix_val)
  );

`ifdef DELAY_LINE_FEEDBACK_EN
  logic [7:0] fb_reg;

  delay_sat_mac u_fb (
    .acc (din_reg),
    .x   (wet_now),
    .g   (fb_reg),
    .y   (wr_val)
  );
`else
  assign wr_val = din_reg;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      wr_ptr_reg     <= '0;
      fill_reg       <= '0;
      d_reg          <= '0;
      wait_cnt_reg   <= '0;
      din_reg        <= '0;
      gain_reg       <= '0;
      mix_reg        <= '0;
      addr1_reg      <= '0;
      addr2_reg      <= '0;
      di_reg         <= '0;
      dout_reg       <= '0;
      we_reg         <= 1'b0;
      dout_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
      in_ready_reg   <= 1'b1;
`ifdef DELAY_LINE_FEEDBACK_EN
      fb_reg         <= '0;
`endif
    end else begin
      we_reg         <= 1'b0;
      dout_valid_reg <= 1'b0;
      if (bus.in_valid && !in_ready_reg)
        overrun_reg <= 1'b1;

      case (state_reg)
        ST_IDLE: begin
          if (bus.in_valid) begin
            din_reg      <= $signed(bus.din);
            gain_reg     <= bus.gain;
`ifdef DELAY_LINE_FEEDBACK_EN
            fb_reg       <= bus.fb;
`endif
            d_reg        <= d_clamp;
            addr1_reg    <= rd_addr;
            in_ready_reg <= 1'b0;
            state_reg    <= ST_RD;
          end
        end
        ST_RD: begin
          wait_cnt_reg <= CW'(RD_LAT - 1);
          state_reg    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt_reg == '0) begin
            mix_reg   <= mix_val;
            di_reg    <= wr_val;
            addr2_reg <= wr_ptr_reg;
            we_reg    <= 1'b1;
            state_reg <= ST_MIX;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
          end
        end
        ST_MIX: begin
          dout_reg       <= mix_reg;
          dout_valid_reg <= 1'b1;
          in_ready_reg   <= 1'b1;
          wr_ptr_reg     <= (wr_ptr_reg == T_LAST) ? '0 : wr_ptr_reg + 1'b1;
          fill_reg       <= (fill_reg == T_EXT) ? fill_reg : fill_reg + 1'b1;
          state_reg      <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_reg;
  assign bus.addr1      = addr1_reg;
  assign bus.addr2      = addr2_reg;
  assign bus.we         = we_reg;
  assign bus.di         = di_reg;
  assign bus.dout       = dout_reg;
  assign bus.dout_valid = dout_valid_reg;
  assign bus.overrun    = overrun_reg;
endmodule

// File: tb/tb_delay_line_ctrl.sv
// tb_delay_line_ctrl: random and directed samples against a history-queue echo model.
module tb_delay_line_ctrl;
  localparam int B      = 6;
  localparam int T      = 16;
  localparam int RD_LAT = 2;

  typedef struct {
    logic [31:0]  dout;
    logic [31:0]  di;
    logic [B-1:0] a1;
    logic [B-1:0] a2;
    int           acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;

  exp_t   wq[$];
  exp_t   dq[$];
  longint hist[$];

  logic [31:0] mem [0:(1<<B)-1];
  logic [31:0] rd_pipe [RD_LAT];

  delay_line_if #(.B(B)) bus ();

  delay_line_ctrl #(.B(B), .T(T), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Two-port delay memory with RD_LAT-cycle registered read.
  always @(posedge clk) begin
    if (bus.we === 1'b1) mem[bus.addr2] <= bus.di;
    rd_pipe[0] <= mem[bus.addr1];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.do1 = rd_pipe[RD_LAT-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  // Monitor: memory write side.
  always @(negedge clk) begin
    exp_t e;
    if (bus.we === 1'b1) begin
      if (wq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_we: got we=1 with nothing pending, expected we=0 (cycle %0d)", cyc);
      end else begin
        e = wq.pop_front();
        chk("addr2", 64'(bus.addr2), 64'(e.a2));
        chk("addr1", 64'(bus.addr1), 64'(e.a1));
        chk("di", 64'(bus.di), 64'(e.di));
        chk("we_cycle", 64'(cyc), 64'(e.acc + 2 + RD_LAT));
      end
    end
  end

  // Monitor: mixed output side.
  always @(negedge clk) begin
    exp_t e;
    if (bus.dout_valid === 1'b1) begin
      if (dq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_dout_valid: got dout=%0h with nothing pending (cycle %0d)", bus.dout, cyc);
      end else begin
        e = dq.pop_front();
        chk("dout", 64'(bus.dout), 64'(e.dout));
        chk("dout_cycle", 64'(cyc), 64'(e.acc + 3 + RD_LAT));
        $display("[TB] sample acc@%0d dout=%0d", e.acc, $signed(bus.dout));
      end
    end
  end

  // Issue one sample; the reference model is the list of values written since reset.
  task automatic send(input logic [31:0] x, input int dly, input int g, input int f);
    int     n, d, waited;
    longint wet, y, w;
    exp_t   e;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: in_ready=%b after %0d cycles, expected 1", bus.in_ready, waited);
      return;
    end
    d   = (dly >= T) ? T - 1 : dly;
    n   = hist.size();
    wet = (d == 0 || n < d) ? 0 : hist[n-d];
    y   = sat32(longint'($signed(x)) + ((wet * g) >>> 8));
`ifdef DELAY_LINE_FEEDBACK_EN
    w   = sat32(longint'($signed(x)) + ((wet * f) >>> 8));
`else
    w   = longint'($signed(x));
`endif
    e.dout = y[31:0];
    e.di   = w[31:0];
    e.a1   = B'(((n % T) - d + T) % T);
    e.a2   = B'(n % T);
    e.acc  = cyc;
    wq.push_back(e);
    dq.push_back(e);
    hist.push_back(w);
    bus.in_valid = 1'b1;
    bus.din      = x;
    bus.delay    = B'(dly);
    bus.gain     = 8'(g);
    bus.fb       = 8'(f);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((wq.size() != 0 || dq.size() != 0) && k < 40) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_we"}, 64'(bus.we), 64'd0);
    chk({tag, "_dout_valid"}, 64'(bus.dout_valid), 64'd0);
    chk({tag, "_overrun"}, 64'(bus.overrun), 64'd0);
    chk({tag, "_addr1"}, 64'(bus.addr1), 64'd0);
    chk({tag, "_addr2"}, 64'(bus.addr2), 64'd0);
    chk({tag, "_di"}, 64'(bus.di), 64'd0);
    chk({tag, "_dout"}, 64'(bus.dout), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wq.delete();
    dq.delete();
    hist.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x;
    int k;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    bus.in_valid = 1'b0;
    bus.din   = '0;
    bus.delay = '0;
    bus.gain  = '0;
    bus.fb    = '0;
    for (int i = 0; i < (1 << B); i++) mem[i] = $urandom;
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic echo: impulse then silence.
    send(32'd1000, 3, 255, 0);
    for (int i = 0; i < 7; i++) send(32'd0, 3, 255, 0);
    drain();

    // Ramp across the buffer wrap.
    for (int i = 0; i < 40; i++) send(32'(i), 5, 255, 0);
    drain();

    // Fill gating after reset, bypass and delay clamp.
    do_reset();
    for (int i = 0; i < 6; i++) send(32'(100 + i), 4, 200, 0);
    for (int i = 0; i < 4; i++) send($urandom, 0, 255, 255);
    for (int i = 0; i < 20; i++) send(32'(i * 7), 40, 128, 0);
    drain();

    // Saturation at both rails, then feedback impulse.
    send(32'h7fff_ff00, 1, 255, 0);
    send(32'h7fff_ff00, 1, 255, 0);
    send(32'h8000_0100, 1, 255, 0);
    send(32'h8000_0100, 1, 255, 0);
    send(32'd1024, 1, 255, 128);
    for (int i = 0; i < 6; i++) send(32'd0, 1, 255, 128);
    drain();

    // Dropped strobe during WAIT.
    send(32'd55, 2, 100, 0);
    chk("overrun_before", 64'(bus.overrun), 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.din      = 32'hdead_beef;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("overrun_set", 64'(bus.overrun), 64'd1);
    send(32'd77, 2, 100, 0);
    drain();
    chk("overrun_sticky", 64'(bus.overrun), 64'd1);

    // Reset asserted in the write cycle.
    send(32'd999, 2, 255, 0);
    k = 0;
    while (bus.we !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("we_seen_before_reset", 64'(bus.we), 64'd1);
    rst_n = 1'b0;
    dq.delete();
    hist.delete();
    @(negedge clk);
    check_reset_outputs("mid_mix_reset");
    rst_n = 1'b1;
    @(negedge clk);
    send(32'd321, 1, 255, 0);
    send(32'd0, 1, 255, 0);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) x = $urandom;
      else x = 32'(int'($urandom_range(0, 20000)) - 10000);
      send(x, int'($urandom_range(0, 40)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end
    drain();

    chk("wq_empty", 64'(wq.size()), 64'd0);
    chk("dq_empty", 64'(dq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
